// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: memory opcodes, memory-stage states and opcode-class helpers.
package lc3_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IND   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for a pending memory request; expire flags the last allowed wait cycle.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// LC3 memory-access stage: sequences direct and indirect loads/stores onto the data-memory port.
//  state | meaning
//  IDLE  | no transaction; accepts a memory opcode when enable_mem is high
//  IND   | pointer read for LDI/STI outstanding
//  READ  | data read outstanding
//  WRITE | data write outstanding
module mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_mem,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] pcout,
    input  logic [15:0] M_Data,
    input  logic [15:0] Data_dout,
    input  logic        Data_ready,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_req,
    output logic        Data_rd,
    output logic [15:0] memout,
    output logic        mem_done,
    output logic        mem_err,
    output logic        mem_busy
);

    mem_state_t  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  opcode;
    logic [15:0] addr_d, din_d, memout_d;
    logic        req_d, rd_d, done_d, err_d;
    logic        tmr_clr, tmr_en, tmr_expire;
    logic        unused_ir;

    assign opcode    = IR_Exec[15:12];
    assign unused_ir = ^IR_Exec[11:0];
    assign mem_busy  = (state_q != IDLE);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clr),
        .enable(tmr_en),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = Data_addr;
        din_d    = Data_din;
        req_d    = Data_req;
        rd_d     = Data_rd;
        memout_d = memout;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_mem && (is_load(opcode) || is_store(opcode))) begin
                    op_d    = opcode;
                    addr_d  = pcout;
                    din_d   = M_Data;
                    req_d   = 1'b1;
                    tmr_clr = 1'b1;
                    if (is_indirect(opcode)) begin
                        state_d = IND;
                        rd_d    = 1'b1;
                    end else if (is_load(opcode)) begin
                        state_d = READ;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = WRITE;
                        rd_d    = 1'b0;
                    end
                end
            end
            default: begin
                if (Data_ready) begin
                    if (state_q == IND) begin
                        // pointer fetched: second access follows with no gap in Data_req
                        addr_d  = Data_dout;
                        tmr_clr = 1'b1;
                        if (is_load(op_q)) begin
                            state_d = READ;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = WRITE;
                            rd_d    = 1'b0;
                        end
                    end else begin
                        if (state_q == READ) memout_d = Data_dout;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmr_expire) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            Data_addr <= 16'd0;
            Data_din  <= 16'd0;
            Data_req  <= 1'b0;
            Data_rd   <= 1'b0;
            memout    <= 16'd0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            Data_addr <= addr_d;
            Data_din  <= din_d;
            Data_req  <= req_d;
            Data_rd   <= rd_d;
            memout    <= memout_d;
            mem_done  <= done_d;
            mem_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, LD with waits, STI, timeout, back-to-back, reset mid-LDI.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_mem;
    logic [15:0] IR_Exec, pcout, M_Data, Data_dout;
    logic        Data_ready;
    logic [15:0] Data_addr, Data_din, memout;
    logic        Data_req, Data_rd, mem_done, mem_err, mem_busy;

    int pass_cnt = 0;
    int total    = 0;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .enable_mem(enable_mem),
        .IR_Exec   (IR_Exec),
        .pcout     (pcout),
        .M_Data    (M_Data),
        .Data_dout (Data_dout),
        .Data_ready(Data_ready),
        .Data_addr (Data_addr),
        .Data_din  (Data_din),
        .Data_req  (Data_req),
        .Data_rd   (Data_rd),
        .memout    (memout),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .mem_busy  (mem_busy)
    );

    always #5 clk = ~clk;

    // advance one rising edge; outputs are then sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable_mem = 1'b1; Data_ready = 1'b1;
        IR_Exec = 16'h2200; pcout = 16'h1111; M_Data = 16'h2222; Data_dout = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({Data_addr, Data_din, memout, Data_req, Data_rd, mem_done, mem_err, mem_busy} !== '0)
                $display("FAIL reset_outputs cyc=%0d addr=%h din=%h memout=%h req=%b rd=%b done=%b err=%b busy=%b, required all 0",
                         i, Data_addr, Data_din, memout, Data_req, Data_rd, mem_done, mem_err, mem_busy);
            else pass_cnt++;
        end
        enable_mem = 1'b0; Data_ready = 1'b0; IR_Exec = 16'h0000;
        rst = 1'b1;
        step();
    endtask

    task automatic test_ld();
        int req_cycles;
        IR_Exec = 16'h2200; pcout = 16'h3010; enable_mem = 1'b1; Data_ready = 1'b0;
        step();
        total++;
        if (!(Data_req === 1'b1 && Data_addr === 16'h3010 && Data_rd === 1'b1 && mem_busy === 1'b1))
            $display("FAIL ld_accept req=%b addr=%h rd=%b busy=%b, required 1 3010 1 1", Data_req, Data_addr, Data_rd, mem_busy);
        else pass_cnt++;
        enable_mem = 1'b0; IR_Exec = 16'h3000; pcout = 16'h0BAD;
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (Data_req === 1'b1) req_cycles++;
            Data_ready = (i == 2);
            Data_dout  = (i == 2) ? 16'hBEEF : 16'h0000;
            step();
        end
        Data_ready = 1'b0;
        total++;
        if (req_cycles !== 3 || Data_req !== 1'b0)
            $display("FAIL ld_req_cycles got=%0d req_now=%b, required 3 and 0", req_cycles, Data_req);
        else pass_cnt++;
        total++;
        if (memout !== 16'hBEEF || mem_done !== 1'b1 || mem_busy !== 1'b0 || Data_addr !== 16'h3010)
            $display("FAIL ld_result memout=%h done=%b busy=%b addr=%h, required BEEF 1 0 3010", memout, mem_done, mem_busy, Data_addr);
        else pass_cnt++;
        step();
        total++;
        if (mem_done !== 1'b0 || mem_err !== 1'b0)
            $display("FAIL ld_done_pulse done=%b err=%b, required 0 0", mem_done, mem_err);
        else pass_cnt++;
    endtask

    task automatic test_sti();
        IR_Exec = 16'hB400; pcout = 16'h4000; M_Data = 16'h1234; enable_mem = 1'b1; Data_ready = 1'b0;
        step();
        total++;
        if (!(Data_req === 1'b1 && Data_addr === 16'h4000 && Data_rd === 1'b1 && Data_din === 16'h1234))
            $display("FAIL sti_ptr_read req=%b addr=%h rd=%b din=%h, required 1 4000 1 1234", Data_req, Data_addr, Data_rd, Data_din);
        else pass_cnt++;
        enable_mem = 1'b0; M_Data = 16'h9999; pcout = 16'h7777;
        Data_ready = 1'b1; Data_dout = 16'h5000;
        step();
        total++;
        if (!(Data_req === 1'b1 && Data_addr === 16'h5000 && Data_rd === 1'b0 && Data_din === 16'h1234 && mem_done === 1'b0))
            $display("FAIL sti_write req=%b addr=%h rd=%b din=%h done=%b, required 1 5000 0 1234 0",
                     Data_req, Data_addr, Data_rd, Data_din, mem_done);
        else pass_cnt++;
        Data_dout = 16'h0000;
        step();
        Data_ready = 1'b0;
        total++;
        if (!(mem_done === 1'b1 && Data_req === 1'b0 && memout === 16'hBEEF && mem_busy === 1'b0))
            $display("FAIL sti_done done=%b req=%b memout=%h busy=%b, required 1 0 BEEF 0", mem_done, Data_req, memout, mem_busy);
        else pass_cnt++;
        step();
    endtask

    task automatic test_timeout();
        int n;
        IR_Exec = 16'h6000; pcout = 16'h1234; enable_mem = 1'b1; Data_ready = 1'b0;
        step();
        enable_mem = 1'b0;
        n = 0;
        while (Data_req === 1'b1 && n < 300) begin
            n++;
            step();
            if (mem_done === 1'b1) begin
                total++;
                $display("FAIL timeout_no_done done=1 at cycle %0d, required 0", n);
            end
        end
        total++;
        if (n !== 255)
            $display("FAIL timeout_req_cycles got=%0d, required 255", n);
        else pass_cnt++;
        total++;
        if (!(mem_err === 1'b1 && mem_done === 1'b0 && mem_busy === 1'b0 && memout === 16'hBEEF))
            $display("FAIL timeout_err err=%b done=%b busy=%b memout=%h, required 1 0 0 BEEF", mem_err, mem_done, mem_busy, memout);
        else pass_cnt++;
        step();
        total++;
        if (mem_err !== 1'b0 || Data_req !== 1'b0)
            $display("FAIL timeout_err_pulse err=%b req=%b, required 0 0", mem_err, Data_req);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        IR_Exec = 16'h3000; pcout = 16'h2000; M_Data = 16'hAAAA; enable_mem = 1'b1; Data_ready = 1'b0;
        step();
        total++;
        if (!(Data_rd === 1'b0 && Data_din === 16'hAAAA && Data_addr === 16'h2000 && Data_req === 1'b1))
            $display("FAIL b2b_st_accept rd=%b din=%h addr=%h req=%b, required 0 AAAA 2000 1", Data_rd, Data_din, Data_addr, Data_req);
        else pass_cnt++;
        enable_mem = 1'b0; Data_ready = 1'b1;
        step();
        total++;
        if (mem_done !== 1'b1)
            $display("FAIL b2b_st_done done=%b, required 1", mem_done);
        else pass_cnt++;
        IR_Exec = 16'h2000; pcout = 16'hFFFF; enable_mem = 1'b1; Data_ready = 1'b0;
        step();
        total++;
        if (!(Data_addr === 16'hFFFF && Data_rd === 1'b1 && Data_req === 1'b1 && mem_busy === 1'b1 && mem_done === 1'b0))
            $display("FAIL b2b_ld_accept addr=%h rd=%b req=%b busy=%b done=%b, required FFFF 1 1 1 0",
                     Data_addr, Data_rd, Data_req, mem_busy, mem_done);
        else pass_cnt++;
        enable_mem = 1'b0; Data_ready = 1'b1; Data_dout = 16'h5555;
        step();
        Data_ready = 1'b0;
        total++;
        if (!(mem_done === 1'b1 && memout === 16'h5555))
            $display("FAIL b2b_ld_done done=%b memout=%h, required 1 5555", mem_done, memout);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_ldi();
        IR_Exec = 16'hA000; pcout = 16'h3000; enable_mem = 1'b1; Data_ready = 1'b0;
        step();
        total++;
        if (mem_busy !== 1'b1 || Data_req !== 1'b1)
            $display("FAIL rmid_ind busy=%b req=%b, required 1 1", mem_busy, Data_req);
        else pass_cnt++;
        enable_mem = 1'b0; rst = 1'b0;
        step();
        total++;
        if (!(Data_req === 1'b0 && mem_busy === 1'b0 && mem_done === 1'b0 && mem_err === 1'b0 && memout === 16'h0000))
            $display("FAIL rmid_abort req=%b busy=%b done=%b err=%b memout=%h, required 0 0 0 0 0000",
                     Data_req, mem_busy, mem_done, mem_err, memout);
        else pass_cnt++;
        rst = 1'b1; IR_Exec = 16'h1042; enable_mem = 1'b1; Data_ready = 1'b1; Data_dout = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (!(Data_req === 1'b0 && mem_busy === 1'b0 && mem_done === 1'b0 && memout === 16'h0000 && Data_addr === 16'h0000))
                $display("FAIL add_ignored cyc=%0d req=%b busy=%b done=%b memout=%h addr=%h, required 0 0 0 0000 0000",
                         i, Data_req, mem_busy, mem_done, memout, Data_addr);
            else pass_cnt++;
        end
        enable_mem = 1'b0; Data_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ld();
        test_sti();
        test_timeout();
        test_back_to_back();
        test_reset_mid_ldi();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
